// File: rtl/alu_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stalls, and
// multi-cycle flush after a taken branch, with a lost-cycle counter.
module alu_hazard_ctrl #(
  parameter int unsigned FLUSH_BUBBLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_write_back,
  input  logic        id_load,
  input  logic        ex_branch_flag,
  input  logic        ex_branch_taken,
  input  logic        mem_stall,
  output logic [1:0]  fwd_op1_sel,
  output logic [1:0]  fwd_op2_sel,
  output logic        stall_if,
  output logic        bubble_ex,
  output logic        flush,
  output logic [31:0] stall_cycles
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wb;
    logic       load;
  } slot_t;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  slot_t         e_q, m_q;
  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [31:0]   stall_cycles_q;

  logic e_hit1, e_hit2, m_hit1, m_hit2;
  logic load_use, take_branch;

  // x0 never matches, so it is never forwarded and never stalls.
  function automatic logic slot_hit(slot_t s, logic [4:0] rs, logic use_rs);
    return s.valid & s.wb & (s.rd != 5'd0) & (s.rd == rs) & use_rs;
  endfunction

  always_comb begin
    e_hit1 = slot_hit(e_q, id_rs1, id_use_rs1);
    e_hit2 = slot_hit(e_q, id_rs2, id_use_rs2);
    m_hit1 = slot_hit(m_q, id_rs1, id_use_rs1);
    m_hit2 = slot_hit(m_q, id_rs2, id_use_rs2);

    fwd_op1_sel = 2'b00;
    if (e_hit1 && !e_q.load) fwd_op1_sel = 2'b01;
    else if (m_hit1)         fwd_op1_sel = 2'b10;

    fwd_op2_sel = 2'b00;
    if (e_hit2 && !e_q.load) fwd_op2_sel = 2'b01;
    else if (m_hit2)         fwd_op2_sel = 2'b10;

    load_use    = id_valid & e_q.load & (e_hit1 | e_hit2);
    take_branch = ex_branch_flag & ex_branch_taken;

    stall_if  = 1'b0;
    bubble_ex = 1'b0;
    flush     = 1'b0;
    if (mem_stall) begin
      stall_if = 1'b1;
    end else if (state_q == StFlush || take_branch) begin
      flush     = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use) begin
      stall_if  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      e_q            <= '0;
      m_q            <= '0;
      state_q        <= StRun;
      cnt_q          <= 3'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      if (stall_if || bubble_ex) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (!mem_stall) begin
        unique case (state_q)
          StRun: begin
            if (take_branch && FLUSH_BUBBLES > 1) begin
              cnt_q   <= 3'(FLUSH_BUBBLES - 1);
              state_q <= StFlush;
            end
          end
          StFlush: begin
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_q <= StRun;
          end
          default: state_q <= StRun;
        endcase
        m_q <= e_q;
        if (id_valid && !bubble_ex) e_q <= '{valid: 1'b1, rd: id_rd, wb: id_write_back,
                                             load: id_load};
        else                        e_q <= '0;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_alu_hazard_ctrl.sv
// Bench for alu_hazard_ctrl: two instances (2 and 4 flush bubbles) driven with the
// same inputs, checked by directed scenarios and a randomized reference model.
module tb_alu_hazard_ctrl;

  localparam int unsigned B0 = 2;
  localparam int unsigned B1 = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_write_back, id_load;
  logic       ex_branch_flag, ex_branch_taken, mem_stall;

  logic [1:0]  f1 [2];
  logic [1:0]  f2 [2];
  logic        si [2];
  logic        bx [2];
  logic        fl [2];
  logic [31:0] sc [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  alu_hazard_ctrl #(.FLUSH_BUBBLES(B0)) dut (
    .CLK(CLK), .RST_N(RST_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_write_back(id_write_back), .id_load(id_load), .ex_branch_flag(ex_branch_flag),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall), .fwd_op1_sel(f1[0]),
    .fwd_op2_sel(f2[0]), .stall_if(si[0]), .bubble_ex(bx[0]), .flush(fl[0]),
    .stall_cycles(sc[0])
  );

  alu_hazard_ctrl #(.FLUSH_BUBBLES(B1)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_write_back(id_write_back), .id_load(id_load), .ex_branch_flag(ex_branch_flag),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall), .fwd_op1_sel(f1[1]),
    .fwd_op2_sel(f2[1]), .stall_if(si[1]), .bubble_ex(bx[1]), .flush(fl[1]),
    .stall_cycles(sc[1])
  );

  // Reference model: in-flight results as records, flush as "cycles still to kill".
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       wb;
    bit       ld;
  } mslot_t;

  mslot_t    me [2];
  mslot_t    mm [2];
  int        frem [2];
  bit [31:0] mcnt [2];
  bit [1:0]  ef1 [2];
  bit [1:0]  ef2 [2];
  bit        esi [2];
  bit        ebx [2];
  bit        efl [2];

  function automatic bit hits(mslot_t s, logic [4:0] rs, logic use_rs);
    return s.v && s.wb && s.rd != 5'd0 && s.rd == rs && use_rs === 1'b1;
  endfunction

  function automatic void model_eval(int k);
    bit h1e, h2e, h1m, h2m;
    h1e = hits(me[k], id_rs1, id_use_rs1);
    h2e = hits(me[k], id_rs2, id_use_rs2);
    h1m = hits(mm[k], id_rs1, id_use_rs1);
    h2m = hits(mm[k], id_rs2, id_use_rs2);
    ef1[k] = (h1e && !me[k].ld) ? 2'd1 : (h1m ? 2'd2 : 2'd0);
    ef2[k] = (h2e && !me[k].ld) ? 2'd1 : (h2m ? 2'd2 : 2'd0);
    esi[k] = 1'b0;
    ebx[k] = 1'b0;
    efl[k] = 1'b0;
    if (mem_stall) begin
      esi[k] = 1'b1;
    end else if (frem[k] > 0 || (ex_branch_flag && ex_branch_taken)) begin
      efl[k] = 1'b1;
      ebx[k] = 1'b1;
    end else if (id_valid && me[k].ld && (h1e || h2e)) begin
      esi[k] = 1'b1;
      ebx[k] = 1'b1;
    end
  endfunction

  function automatic void model_step(int k, int nbub);
    model_eval(k);
    if (!RST_N) begin
      me[k] = '0; mm[k] = '0; frem[k] = 0; mcnt[k] = 32'd0;
      return;
    end
    if (esi[k] || ebx[k]) mcnt[k] = mcnt[k] + 32'd1;
    if (!mem_stall) begin
      if (frem[k] > 0) frem[k] = frem[k] - 1;
      else if (ex_branch_flag && ex_branch_taken) frem[k] = nbub - 1;
      mm[k] = me[k];
      if (id_valid && !ebx[k]) me[k] = '{v: 1'b1, rd: id_rd, wb: id_write_back, ld: id_load};
      else me[k] = '0;
    end
  endfunction

  // Advance one clock; model consumes the inputs held over this edge.
  task automatic tick();
    model_step(0, B0);
    model_step(1, B1);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_write_back = 0; id_load = 0; ex_branch_flag = 0; ex_branch_taken = 0; mem_stall = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wb, input logic ld,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    id_valid = 1; id_rd = rd; id_write_back = wb; id_load = ld;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
  endtask

  task automatic do_reset();
    set_idle();
    RST_N = 0;
    tick();
    tick();
    RST_N = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (f1[k] !== 2'b00 || f2[k] !== 2'b00)
        $display("FAIL reset_sel[%0d] got=%0d/%0d exp=0/0", k, f1[k], f2[k]); else n_pass++;
      n_checks++; if ({si[k], bx[k], fl[k]} !== 3'b000)
        $display("FAIL reset_ctl[%0d] got=%b exp=000", k, {si[k], bx[k], fl[k]}); else n_pass++;
      n_checks++; if (sc[k] !== 32'd0)
        $display("FAIL reset_cnt[%0d] got=%0d exp=0", k, sc[k]); else n_pass++;
    end
  endtask

  task automatic test_forward();
    do_reset();
    issue(5, 1, 0, 0, 0, 0, 0);
    tick();
    issue(6, 1, 0, 5, 1, 5, 1);
    #1;
    n_checks++; if (f1[0] !== 2'b01 || f2[0] !== 2'b01)
      $display("FAIL fwd_alu got=%0d/%0d exp=1/1", f1[0], f2[0]); else n_pass++;
    tick();
    issue(7, 1, 0, 5, 1, 5, 1);
    #1;
    n_checks++; if (f1[0] !== 2'b10 || f2[0] !== 2'b10)
      $display("FAIL fwd_mem got=%0d/%0d exp=2/2", f1[0], f2[0]); else n_pass++;
    tick();
    issue(0, 1, 0, 0, 0, 0, 0);
    tick();
    issue(1, 1, 0, 0, 1, 0, 1);
    #1;
    n_checks++; if (f1[0] !== 2'b00 || f2[0] !== 2'b00)
      $display("FAIL fwd_x0 got=%0d/%0d exp=0/0", f1[0], f2[0]); else n_pass++;
    tick();
    issue(3, 1, 0, 0, 0, 0, 0);
    tick();
    issue(3, 1, 0, 0, 0, 0, 0);
    tick();
    issue(4, 1, 0, 3, 1, 3, 0);
    #1;
    n_checks++; if (f1[0] !== 2'b01 || f2[0] !== 2'b00)
      $display("FAIL fwd_e_priority got=%0d/%0d exp=1/0", f1[0], f2[0]); else n_pass++;
    tick();
    set_idle();
  endtask

  task automatic test_load_use();
    do_reset();
    issue(7, 1, 1, 0, 0, 0, 0);
    tick();
    issue(8, 1, 0, 7, 1, 1, 1);
    #1;
    n_checks++; if (si[0] !== 1'b1 || bx[0] !== 1'b1 || f1[0] !== 2'b00)
      $display("FAIL load_use_stall got=si%b bx%b sel%0d exp=si1 bx1 sel0",
               si[0], bx[0], f1[0]); else n_pass++;
    tick();
    #1;
    n_checks++; if (si[0] !== 1'b0 || bx[0] !== 1'b0)
      $display("FAIL load_use_release got=si%b bx%b exp=si0 bx0", si[0], bx[0]); else n_pass++;
    n_checks++; if (f1[0] !== 2'b10 || f2[0] !== 2'b00)
      $display("FAIL load_use_fwd got=%0d/%0d exp=2/0", f1[0], f2[0]); else n_pass++;
    n_checks++; if (sc[0] !== 32'd1)
      $display("FAIL load_use_cnt got=%0d exp=1", sc[0]); else n_pass++;
    tick();
    set_idle();
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_flag = 1; ex_branch_taken = 1;
    #1;
    n_checks++; if (fl[0] !== 1'b1 || bx[0] !== 1'b1 || fl[1] !== 1'b1)
      $display("FAIL branch_t0 got=fl%b bx%b fl4%b exp=111", fl[0], bx[0], fl[1]); else n_pass++;
    tick();
    ex_branch_flag = 0; ex_branch_taken = 0;
    #1;
    n_checks++; if (fl[0] !== 1'b1 || bx[0] !== 1'b1)
      $display("FAIL branch_t1 got=fl%b bx%b exp=11", fl[0], bx[0]); else n_pass++;
    tick();
    #1;
    n_checks++; if (fl[0] !== 1'b0 || bx[0] !== 1'b0 || fl[1] !== 1'b1)
      $display("FAIL branch_t2 got=fl%b bx%b fl4%b exp=001", fl[0], bx[0], fl[1]); else n_pass++;
    tick();
    tick();
    #1;
    n_checks++; if (fl[1] !== 1'b0)
      $display("FAIL branch4_t4 got=%b exp=0", fl[1]); else n_pass++;
    ex_branch_flag = 1; ex_branch_taken = 0;
    #1;
    n_checks++; if (fl[0] !== 1'b0 || bx[0] !== 1'b0)
      $display("FAIL branch_not_taken got=fl%b bx%b exp=00", fl[0], bx[0]); else n_pass++;
    tick();
    set_idle();
  endtask

  task automatic test_mem_stall();
    do_reset();
    issue(9, 1, 0, 0, 0, 0, 0);
    tick();
    issue(10, 1, 0, 9, 1, 0, 0);
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (si[0] !== 1'b1 || bx[0] !== 1'b0 || f1[0] !== 2'b01)
        $display("FAIL mem_stall[%0d] got=si%b bx%b sel%0d exp=si1 bx0 sel1",
                 i, si[0], bx[0], f1[0]); else n_pass++;
      tick();
    end
    mem_stall = 0;
    #1;
    n_checks++; if (f1[0] !== 2'b01 || si[0] !== 1'b0)
      $display("FAIL mem_stall_release got=sel%0d si%b exp=sel1 si0", f1[0], si[0]); else n_pass++;
    n_checks++; if (sc[0] !== 32'd3)
      $display("FAIL mem_stall_cnt got=%0d exp=3", sc[0]); else n_pass++;
    tick();
    set_idle();
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    ex_branch_flag = 1; ex_branch_taken = 1;
    tick();
    ex_branch_flag = 0; ex_branch_taken = 0;
    RST_N = 0;
    #1;
    n_checks++; if (fl[1] !== 1'b1)
      $display("FAIL rst_flush_t1 got=%b exp=1", fl[1]); else n_pass++;
    tick();
    RST_N = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (fl[1] !== 1'b0 || bx[1] !== 1'b0)
        $display("FAIL rst_flush_after[%0d] got=fl%b bx%b exp=00", i, fl[1], bx[1]); else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (sc[1] !== 32'd0)
      $display("FAIL rst_flush_cnt got=%0d exp=0", sc[1]); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      RST_N = ($urandom_range(0, 39) != 0);
      mem_stall = ($urandom_range(0, 5) == 0);
      id_valid = $urandom_range(0, 1);
      id_rd = 5'($urandom_range(0, 3));
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_use_rs1 = $urandom_range(0, 1);
      id_use_rs2 = $urandom_range(0, 1);
      id_write_back = ($urandom_range(0, 3) != 0);
      id_load = ($urandom_range(0, 2) == 0);
      // Branches only arrive when neither instance is mid-flush.
      if (frem[0] == 0 && frem[1] == 0 && $urandom_range(0, 7) == 0) begin
        ex_branch_flag = 1; ex_branch_taken = $urandom_range(0, 1);
      end else begin
        ex_branch_flag = 0; ex_branch_taken = 0;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        model_eval(k);
        n_checks++; if (f1[k] !== ef1[k] || f2[k] !== ef2[k])
          $display("FAIL rnd_sel[%0d] cyc=%0d got=%0d/%0d exp=%0d/%0d",
                   k, c, f1[k], f2[k], ef1[k], ef2[k]); else n_pass++;
        n_checks++; if ({si[k], bx[k], fl[k]} !== {esi[k], ebx[k], efl[k]})
          $display("FAIL rnd_ctl[%0d] cyc=%0d got=%b exp=%b", k, c,
                   {si[k], bx[k], fl[k]}, {esi[k], ebx[k], efl[k]}); else n_pass++;
        n_checks++; if (sc[k] !== mcnt[k])
          $display("FAIL rnd_cnt[%0d] cyc=%0d got=%0d exp=%0d", k, c, sc[k], mcnt[k]);
        else n_pass++;
      end
      tick();
    end
    RST_N = 1;
    set_idle();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      me[k] = '0; mm[k] = '0; frem[k] = 0; mcnt[k] = 32'd0;
    end
    set_idle();
    RST_N = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_stall();
    test_reset_in_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
